// File: rtl/tnn_first_layer_sequencer.sv
// Sequences one ternary first layer per input vector: load, pulse layer reset, run, settle, hand off.
// Optional TNN_SEQ_STATS_EN adds stat_samples / stat_last_lat counters.
module tnn_first_layer_sequencer #(
    parameter int FEAT_CNT      = 4,
    parameter int FEAT_BITS     = 4,
    parameter int HIDDEN_CNT    = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RUN       = FEAT_CNT + 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [FEAT_CNT*FEAT_BITS-1:0] s_features,
    output logic [FEAT_CNT*FEAT_BITS-1:0] layer_features,
    output logic                          layer_rst,
    input  logic                          layer_done,
    input  logic [HIDDEN_CNT-1:0]         layer_out,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [HIDDEN_CNT-1:0]         m_act,
    output logic                          busy,
    output logic                          err_timeout
`ifdef TNN_SEQ_STATS_EN
    ,
    output logic [15:0]                   stat_samples,
    output logic [7:0]                    stat_last_lat
`endif
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN - 1);
    localparam logic [RUN_W-1:0] RUN_SAT  = '1;
    localparam logic [3:0] SETTLE_INIT = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        HOLD
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic [3:0]       settle_cnt;
    logic             done_hit;
    logic             timeout_hit;
    logic             settle_hit;
    logic             enter_hold;

    assign s_ready = (state == IDLE);
    assign busy    = (state != IDLE);

    // Done wins over the watchdog when both land on the same edge.
    always_comb begin
        done_hit    = (state == RUN) && layer_done;
        timeout_hit = (state == RUN) && !layer_done && (run_cnt == RUN_LAST);
        settle_hit  = (state == SETTLE) && (settle_cnt == 4'd0);
        enter_hold  = timeout_hit || settle_hit || (done_hit && (SETTLE_CYCLES == 0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            layer_rst      <= 1'b1;
            layer_features <= '0;
            m_valid        <= 1'b0;
            m_act          <= '0;
            err_timeout    <= 1'b0;
            run_cnt        <= '0;
            settle_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        layer_features <= s_features;
                        layer_rst      <= 1'b1;
                        state          <= CLEAR;
                    end
                end
                CLEAR: begin
                    layer_rst <= 1'b0;
                    run_cnt   <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    if (run_cnt != RUN_SAT) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                    if (done_hit) begin
                        if (SETTLE_CYCLES == 0) begin
                            m_act   <= layer_out;
                            m_valid <= 1'b1;
                            state   <= HOLD;
                        end else begin
                            settle_cnt <= SETTLE_INIT;
                            state      <= SETTLE;
                        end
                    end else if (timeout_hit) begin
                        // Emit an all-zero result so the downstream stream never stalls.
                        err_timeout <= 1'b1;
                        m_act       <= '0;
                        m_valid     <= 1'b1;
                        state       <= HOLD;
                    end
                end
                SETTLE: begin
                    if (settle_hit) begin
                        m_act   <= layer_out;
                        m_valid <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid   <= 1'b0;
                        layer_rst <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TNN_SEQ_STATS_EN
    logic [7:0] lat_cnt;

    // lat_cnt holds the number of edges since acceptance, so it equals the latency on the capture edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt       <= '0;
            stat_samples  <= '0;
            stat_last_lat <= '0;
        end else begin
            if (state == IDLE) begin
                lat_cnt <= s_valid ? 8'd1 : 8'd0;
            end else if (lat_cnt != 8'hFF) begin
                lat_cnt <= lat_cnt + 8'd1;
            end
            if (enter_hold) begin
                stat_last_lat <= lat_cnt;
            end
            if (m_valid && m_ready) begin
                stat_samples <= stat_samples + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tnn_first_layer_sequencer.sv
// Directed bench: DUT a (SETTLE_CYCLES=1) with an accumulating ternary layer model,
// DUT b (SETTLE_CYCLES=0) with a combinational layer stub for back-to-back ordering.
module tb_tnn_first_layer_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s_valid_a = 1'b0, s_ready_a, lrst_a, done_a, m_valid_a, m_ready_a = 1'b1, busy_a, err_a;
    logic [15:0] s_feat_a = '0, lf_a;
    logic [3:0]  lo_a, m_act_a;
    logic        kill_a = 1'b0;

    logic        s_valid_b = 1'b0, s_ready_b, lrst_b, done_b, m_valid_b, m_ready_b = 1'b1, busy_b, err_b;
    logic [15:0] s_feat_b = '0, lf_b;
    logic [3:0]  lo_b, m_act_b;

`ifdef TNN_SEQ_STATS_EN
    logic [15:0] ss_a, ss_b;
    logic [7:0]  sl_a, sl_b;
`endif

    tnn_first_layer_sequencer #(.SETTLE_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_features(s_feat_a),
        .layer_features(lf_a), .layer_rst(lrst_a), .layer_done(done_a), .layer_out(lo_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_act(m_act_a), .busy(busy_a), .err_timeout(err_a)
`ifdef TNN_SEQ_STATS_EN
        , .stat_samples(ss_a), .stat_last_lat(sl_a)
`endif
    );

    tnn_first_layer_sequencer #(.SETTLE_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_features(s_feat_b),
        .layer_features(lf_b), .layer_rst(lrst_b), .layer_done(done_b), .layer_out(lo_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_act(m_act_b), .busy(busy_b), .err_timeout(err_b)
`ifdef TNN_SEQ_STATS_EN
        , .stat_samples(ss_b), .stat_last_lat(sl_b)
`endif
    );

    // Ternary weights, bit n*4+i: neuron n, feature i.
    logic [15:0] wpos = 16'h9401;
    logic [15:0] wneg = 16'h2210;
    logic [2:0]  idx_a, idx_b;
    int          acc_a [4];

    function automatic int contrib(input int n, input int i);
        int f;
        f = int'(lf_a[i*4 +: 4]);
        contrib = 0;
        if (wpos[n*4+i]) contrib = f;
        if (wneg[n*4+i]) contrib = -f;
    endfunction

    always @(posedge clk) begin
        if (lrst_a) begin
            idx_a <= 3'd0;
            for (int n = 0; n < 4; n++) acc_a[n] <= 0;
        end else if (idx_a < 3'd4) begin
            for (int n = 0; n < 4; n++) acc_a[n] <= acc_a[n] + contrib(n, int'(idx_a));
            idx_a <= idx_a + 3'd1;
        end
    end

    always_comb begin
        lo_a = '0;
        for (int n = 0; n < 4; n++) lo_a[n] = (acc_a[n] > 0);
    end
    assign done_a = (idx_a == 3'd3) && !kill_a;

    always @(posedge clk) begin
        if (lrst_b) idx_b <= 3'd0;
        else if (idx_b < 3'd4) idx_b <= idx_b + 3'd1;
    end
    assign done_b = (idx_b == 3'd3);
    assign lo_b   = lf_b[3:0] ^ lf_b[7:4];

    logic [3:0] res_q [$];
    int         rcyc_q [$];
    always @(negedge clk) begin
        if (m_valid_b && m_ready_b) begin
            res_q.push_back(m_act_b);
            rcyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_mv_a(input string tag, input int e0, output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_valid_a) begin
                lat = cyc - e0;
                break;
            end
        end
        chk({tag, "_mvalid_seen"}, 32'(m_valid_a), 1);
    endtask

    task automatic run_a(input logic [15:0] feat, input logic [3:0] exp_act, input int exp_lat,
                         input logic exp_err, input string tag);
        int e0, lat;
        @(negedge clk);
        s_feat_a  = feat;
        s_valid_a = 1'b1;
        m_ready_a = 1'b1;
        chk({tag, "_s_ready"}, 32'(s_ready_a), 1);
        @(posedge clk); #1;
        e0        = cyc;
        s_valid_a = 1'b0;
        s_feat_a  = 16'hDEAD;
        chk({tag, "_layer_feat"}, 32'(lf_a), 32'(feat));
        chk({tag, "_busy"}, 32'(busy_a), 1);
        chk({tag, "_s_ready_busy"}, 32'(s_ready_a), 0);
        wait_mv_a(tag, e0, lat);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_m_act"}, 32'(m_act_a), 32'(exp_act));
        chk({tag, "_err"}, 32'(err_a), 32'(exp_err));
        chk({tag, "_feat_stable"}, 32'(lf_a), 32'(feat));
        @(posedge clk); #1;
        chk({tag, "_s_ready_after"}, 32'(s_ready_a), 1);
        chk({tag, "_m_valid_after"}, 32'(m_valid_a), 0);
        chk({tag, "_layer_rst_after"}, 32'(lrst_a), 1);
    endtask

    logic [15:0] vb [3] = '{16'h0012, 16'h0034, 16'h00C5};
    logic [3:0]  vb_exp [3] = '{4'h3, 4'h7, 4'h9};
    int          acc_cyc [3];

    initial begin
        int e0, lat;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready_a), 1);
        chk("rst_layer_rst", 32'(lrst_a), 1);
        chk("rst_m_valid", 32'(m_valid_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_layer_feat", 32'(lf_a), 0);
        chk("rst_m_act", 32'(m_act_a), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_s_ready", 32'(s_ready_a), 1);
        chk("idle_layer_rst", 32'(lrst_a), 1);

        run_a(16'hA5C3, 4'b1001, 6, 1'b0, "single");
        run_a(16'h8F02, 4'b1101, 6, 1'b0, "single2");

        // Result held off by m_ready low; a waiting vector must not be taken early.
        @(negedge clk);
        s_feat_a  = 16'h8F02;
        s_valid_a = 1'b1;
        m_ready_a = 1'b0;
        @(posedge clk); #1;
        e0        = cyc;
        s_valid_a = 1'b0;
        wait_mv_a("hold", e0, lat);
        chk("hold_latency", lat, 6);
        s_feat_a  = 16'h0F00;
        s_valid_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_m_valid", 32'(m_valid_a), 1);
            chk("hold_m_act", 32'(m_act_a), 32'(4'b1101));
            chk("hold_s_ready", 32'(s_ready_a), 0);
            chk("hold_layer_feat", 32'(lf_a), 32'(16'h8F02));
        end
        m_ready_a = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_m_valid", 32'(m_valid_a), 0);
        chk("hold_release_s_ready", 32'(s_ready_a), 1);
        chk("hold_no_same_cycle_accept", 32'(lf_a), 32'(16'h8F02));
        @(posedge clk); #1;
        e0        = cyc;
        s_valid_a = 1'b0;
        chk("hold_second_feat", 32'(lf_a), 32'(16'h0F00));
        wait_mv_a("hold2", e0, lat);
        chk("hold2_latency", lat, 6);
        chk("hold2_m_act", 32'(m_act_a), 32'(4'b0100));

        // Watchdog: done never arrives, result after 8 RUN cycles is zero with sticky error.
        kill_a = 1'b1;
        run_a(16'hA5C3, 4'b0000, 9, 1'b1, "timeout");
        kill_a = 1'b0;
        run_a(16'h0F00, 4'b0100, 6, 1'b1, "sticky1");
        run_a(16'hA5C3, 4'b1001, 6, 1'b1, "sticky2");

        // Reset while in SETTLE drops the vector and clears the error.
        @(negedge clk);
        s_feat_a  = 16'hA5C3;
        s_valid_a = 1'b1;
        @(posedge clk); #1;
        s_valid_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("settle_busy", 32'(busy_a), 1);
        chk("settle_m_valid", 32'(m_valid_a), 0);
        rst = 1'b1;
        #1;
        chk("midrst_s_ready", 32'(s_ready_a), 1);
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_layer_rst", 32'(lrst_a), 1);
        chk("midrst_err", 32'(err_a), 0);
        chk("midrst_layer_feat", 32'(lf_a), 0);
        chk("midrst_m_act", 32'(m_act_a), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_output", 32'(m_valid_a), 0);
        run_a(16'h8F02, 4'b1101, 6, 1'b0, "post_rst");

        // Back-to-back on the zero-settle instance.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_feat_b  = vb[i];
            s_valid_b = 1'b1;
            for (int k = 0; k < 20 && !s_ready_b; k++) @(negedge clk);
            chk("b2b_s_ready", 32'(s_ready_b), 1);
            @(posedge clk); #1;
            acc_cyc[i] = cyc;
            s_valid_b  = 1'b0;
        end
        repeat (10) @(negedge clk);
        chk("b2b_count", res_q.size(), 3);
        if (res_q.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("b2b_act", 32'(res_q[i]), 32'(vb_exp[i]));
            chk("b2b_latency", rcyc_q[0] - acc_cyc[0], 5);
            chk("b2b_res_gap1", rcyc_q[1] - rcyc_q[0], 7);
            chk("b2b_res_gap2", rcyc_q[2] - rcyc_q[1], 7);
            chk("b2b_acc_gap", acc_cyc[2] - acc_cyc[1], 7);
        end
        chk("b2b_err", 32'(err_b), 0);
`ifdef TNN_SEQ_STATS_EN
        chk("stat_samples", 32'(ss_b), 3);
        chk("stat_last_lat", 32'(sl_b), 5);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tnn_first_layer_sequencer.md
Name: tnn_first_layer_sequencer

Overview:
Controller that sequences one ternary first-layer instance (sparse per-neuron accumulators plus a feature-index counter that raises done at index FEAT_CNT-1) over a stream of feature vectors. It accepts a vector over a valid/ready handshake, holds it stable, pulses the layer's reset and waits for layer done plus a settle window. It then captures the HIDDEN_CNT-bit activation vector and presents it downstream over valid/ready. It also runs a sticky watchdog on the layer's run time.

Parameters:
FEAT_CNT, 4, feature count; must match the sequenced layer
FEAT_BITS, 4, bits per feature
HIDDEN_CNT, 4, hidden neurons (layer output width)
SETTLE_CYCLES, 1, cycles between layer done and capture (0..15) to cover the accumulator output register
MAX_RUN, FEAT_CNT+4, RUN-state cycles allowed before watchdog error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_valid  in  1  input vector valid
s_ready  out  1  sequencer can accept a vector
s_features  in  FEAT_CNT*FEAT_BITS  input vector
layer_features  out  FEAT_CNT*FEAT_BITS  registered vector driving the layer
layer_rst  out  1  registered reset pulse to the layer
layer_done  in  1  layer done (index reached FEAT_CNT-1)
layer_out  in  HIDDEN_CNT  layer activations
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_act  out  HIDDEN_CNT  captured activations
busy  out  1  state != IDLE
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: reset is rst, asynchronous, active-high; clock is clk. State=IDLE. s_ready=1 (combinational, IDLE). layer_rst=1 (layer held cleared). layer_features=0, m_valid=0, m_act=0, busy=0, err_timeout=0. All internal counters are 0.
- FSM states: IDLE, CLEAR, RUN, SETTLE, HOLD.
- IDLE: s_ready=1. On s_valid at an edge:
  - layer_features<=s_features.
  - layer_rst<=1 (already 1 after reset; layer_rst returns to 1 on every entry to IDLE).
  - Go to CLEAR.
- CLEAR: lasts exactly 1 cycle. At its closing edge layer_rst<=0, run_cnt<=0, go to RUN.
- RUN: run_cnt increments each cycle, saturating.
  - On layer_done=1 at an edge: if SETTLE_CYCLES=0, capture (m_act<=layer_out, m_valid<=1) and go to HOLD; otherwise set settle_cnt<=SETTLE_CYCLES-1 and go to SETTLE.
  - If run_cnt reaches MAX_RUN without done: err_timeout<=1 (sticky), m_act<=0, m_valid<=1, go to HOLD. This keeps the stream alive.
- SETTLE: decrements settle_cnt. At the edge where settle_cnt=0: capture and go to HOLD.
- HOLD:
  - m_valid=1; m_act stable.
  - On m_ready: m_valid<=0, layer_rst<=1, go to IDLE.
  - A new vector cannot be accepted in the same cycle (s_ready=0 outside IDLE).
- Latency: for a handshake at edge E0, m_valid rises after edge E0+FEAT_CNT+1+SETTLE_CYCLES.
- Throughput: one vector per FEAT_CNT+3+SETTLE_CYCLES cycles with m_ready held high.
- layer_features are stable from CLEAR through HOLD. s_features changes outside IDLE are ignored.
- layer_done is ignored outside RUN, including a stale done while layer_rst is high.
- m_ready without m_valid has no effect.
- rst mid-operation: immediate return to reset values. Any in-flight vector is dropped with no output, and err_timeout is cleared.

Optional Feature:
TNN_SEQ_STATS_EN
- Defined: adds output stat_samples (16 bits) and output stat_last_lat (8 bits).
  - stat_samples increments, wrapping, on each m_valid&m_ready.
  - stat_last_lat records the cycle count from the input handshake edge to the m_valid rise, saturating at 255.
  - Both are 0 at reset.
- Undefined: these ports and their counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then idle with FEAT_CNT=4 -> s_ready=1, layer_rst=1, m_valid=0, err_timeout=0, busy=0.
- Single vector 16'hA5C3 with a reference layer model, SETTLE_CYCLES=1, m_ready=1 -> layer_features=16'hA5C3; m_valid rises after edge E0+6; m_act equals the model output; s_ready returns 1 after the acceptance edge.
- m_ready held low for 10 cycles in HOLD -> m_valid stays 1, m_act stable, s_ready=0; a second s_valid is not accepted until after the acceptance.
- Layer model with done tied low, MAX_RUN=8 -> err_timeout=1 after 8 RUN cycles, m_valid=1 with m_act=0; err_timeout stays 1 over subsequent good vectors until rst.
- Assert rst while in SETTLE -> all outputs back to reset values the same cycle; next vector processed with normal latency.
- Back-to-back 3 vectors, m_ready=1, SETTLE_CYCLES=0 -> 3 results in order, spaced 7 cycles. With TNN_SEQ_STATS_EN: stat_samples=3, stat_last_lat=5.
